clock_tick_gen: RTL and testbench

//   Parametrised timebase for the digital clock. Divides CLOCK_50 into a 1 Hz

---
 rtl/clock_tick_gen.sv | 191 +++++++++++++++++++
 tb/tb_clock_tick_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_tick_gen.sv
// clock_tick_gen: timebase for the digital clock.
//   - Quarter counter + 2-bit phase produce the 1 Hz tick, the 1 Hz square
//     wave (clk_1hz) and the 2 Hz blink square wave.
//   - An independent scan counter produces scan_tick and a wrapping digit
//     index for the 7-segment multiplexer.
//   - enable pauses the timebase, sync_clr restarts its phase, and fast_mode
//     shortens the quarter period by FAST_DIV.
// Optional feature: define TICK_CAL_EN to add the signed cal_trim input,
// which trims the normal-mode quarter period.
module clock_tick_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int FAST_DIV = 60,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 4,
  parameter int CNT_W    = 26,
  localparam int SEL_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic             fast_mode,
`ifdef TICK_CAL_EN
  input  logic [7:0]       cal_trim,
`endif
  output logic             tick_1hz,
  output logic             clk_1hz,
  output logic             blink,
  output logic             scan_tick,
  output logic [SEL_W-1:0] scan_sel
);

  // Derived timing constants (in CLOCK_50 cycles).
  localparam int Q  = CLK_HZ / (4 * TICK_HZ);  // normal quarter period
  localparam int QF = Q / FAST_DIV;            // fast quarter period
  localparam int SD = CLK_HZ / SCAN_HZ;        // scan period

  localparam logic [CNT_W-1:0] QT_NORM = CNT_W'(Q - 1);
  localparam logic [CNT_W-1:0] QT_FAST = CNT_W'(QF - 1);
  localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(SD - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  // Reject configurations that cannot produce a valid timebase.
  generate
    if (QF < 1) begin : g_bad_fast
      $error("clock_tick_gen: Q/FAST_DIV must be at least 1");
    end
    if (SD < 2) begin : g_bad_scan
      $error("clock_tick_gen: scan period must be at least 2 cycles");
    end
    if ((longint'(Q) - 1) >= (longint'(1) << CNT_W) ||
        (longint'(SD) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_width
      $error("clock_tick_gen: CNT_W too narrow for Q-1 or SD-1");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Timebase state
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] qc_q, qc_d;
  logic [1:0]       phase_q, phase_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] qt_norm;  // effective normal-mode terminal count
  logic [CNT_W-1:0] qt;       // terminal count in use this cycle
  logic             wrap;     // quarter completes on this edge

`ifdef TICK_CAL_EN
  localparam logic signed [CNT_W+1:0] QT_NORM_S = (CNT_W+2)'(Q - 1);
  localparam logic signed [CNT_W+1:0] QT_MIN_S  = (CNT_W+2)'(1);
  localparam logic signed [CNT_W+1:0] QT_MAX_S  = $signed({2'b00, {CNT_W{1'b1}}});

  logic signed [7:0]       cal_q, cal_d;
  logic signed [CNT_W+1:0] qt_cal;

  // Trimmed normal-mode terminal count, clamped to the counter's legal range.
  always_comb begin
    qt_cal = QT_NORM_S + (CNT_W+2)'(cal_q);
    if (qt_cal < QT_MIN_S) begin
      qt_norm = CNT_W'(1);
    end else if (qt_cal > QT_MAX_S) begin
      qt_norm = {CNT_W{1'b1}};
    end else begin
      qt_norm = qt_cal[CNT_W-1:0];
    end
  end

  // Trim value is captured only at a quarter boundary, so a change always
  // applies to a whole quarter.
  always_comb begin
    cal_d = cal_q;
    if (wrap) begin
      cal_d = $signed(cal_trim);
    end
  end

  // Trim register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cal_q <= '0;
    end else begin
      cal_q <= cal_d;
    end
  end
`else
  assign qt_norm = QT_NORM;
`endif

  // A >= compare (not ==) lets a switch into fast_mode with qc already past
  // the shorter terminal count wrap immediately instead of overrunning.
  assign qt   = fast_mode ? QT_FAST : qt_norm;
  assign wrap = !sync_clr && enable && (qc_q >= qt);

  // Timebase next state: clear beats enable; pause holds qc and phase.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the if/else tree can leave it unassigned and infer a latch.
    qc_d    = qc_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    if (sync_clr) begin
      qc_d    = '0;
      phase_d = '0;
    end else if (enable) begin
      if (wrap) begin
        qc_d    = '0;
        phase_d = phase_q + 2'd1;
        // Pulse in the same cycle phase becomes 2, i.e. clk_1hz rises.
        tick_d  = (phase_q == 2'd1);
      end else begin
        qc_d = qc_q + CNT_W'(1);
      end
    end
  end

  // Timebase registers.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      qc_q    <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      qc_q    <= qc_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  // ---------------------------------------------------------------------
  // Scan path: free running, only reset clears it
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] sc_q, sc_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             scan_tick_q, scan_tick_d;

  // Scan next state: wrap at SD-1, pulse, and advance the digit index.
  always_comb begin
    sc_d        = sc_q + CNT_W'(1);
    sel_d       = sel_q;
    scan_tick_d = 1'b0;
    if (sc_q == SD_LAST) begin
      sc_d        = '0;
      scan_tick_d = 1'b1;
      sel_d       = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    end
  end

  // Scan registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sc_q        <= '0;
      sel_q       <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      sc_q        <= sc_d;
      sel_q       <= sel_d;
      scan_tick_q <= scan_tick_d;
    end
  end

  // All outputs come straight from flops.
  assign tick_1hz  = tick_q;
  assign clk_1hz   = phase_q[1];
  assign blink     = phase_q[0];
  assign scan_tick = scan_tick_q;
  assign scan_sel  = sel_q;

endmodule

// File: tb/tb_clock_tick_gen.sv
// Self-checking bench for clock_tick_gen: directed timing scenarios followed
// by randomized stimulus compared every cycle against a behavioural model.
module tb_clock_tick_gen;

  localparam int CLK_HZ   = 64;
  localparam int TICK_HZ  = 1;
  localparam int FAST_DIV = 4;
  localparam int SCAN_HZ  = 16;
  localparam int DIGITS   = 4;
  localparam int CNT_W    = 8;
  localparam int Q        = CLK_HZ / (4 * TICK_HZ);  // 16
  localparam int SD       = CLK_HZ / SCAN_HZ;        // 4

  logic       clk = 1'b0;
  logic       reset, enable, sync_clr, fast_mode;
  logic       tick_1hz, clk_1hz, blink, scan_tick;
  logic [1:0] scan_sel;
`ifdef TICK_CAL_EN
  logic [7:0] cal_trim;
`endif

  always #5 clk = ~clk;

  clock_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .FAST_DIV(FAST_DIV),
    .SCAN_HZ (SCAN_HZ),
    .DIGITS  (DIGITS),
    .CNT_W   (CNT_W)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .enable   (enable),
    .sync_clr (sync_clr),
    .fast_mode(fast_mode),
`ifdef TICK_CAL_EN
    .cal_trim (cal_trim),
`endif
    .tick_1hz (tick_1hz),
    .clk_1hz  (clk_1hz),
    .blink    (blink),
    .scan_tick(scan_tick),
    .scan_sel (scan_sel)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Behavioural model: total cycles since reset, position within the current
  // quarter, and an unbounded count of completed quarters.
  longint m_n, m_pos, m_quarters;
  bit     m_tick;
`ifdef TICK_CAL_EN
  int     m_cal;
`endif

  function automatic int quarter_last();
    int t;
    if (fast_mode) return Q / FAST_DIV - 1;
    t = Q - 1;
`ifdef TICK_CAL_EN
    t = t + m_cal;
    if (t < 1) t = 1;
`endif
    return t;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_n = 0; m_pos = 0; m_quarters = 0; m_tick = 0;
`ifdef TICK_CAL_EN
      m_cal = 0;
`endif
    end else begin
      m_n++;
      m_tick = 0;
      if (sync_clr) begin
        m_pos = 0;
        m_quarters = 0;
      end else if (enable) begin
        if (m_pos >= quarter_last()) begin
          m_pos = 0;
          m_quarters++;
          m_tick = (m_quarters % 4 == 2);
`ifdef TICK_CAL_EN
          m_cal = int'($signed(cal_trim));
`endif
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  // One clock: update the model at the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("tick_1hz",  tick_1hz,  longint'(m_tick));
    check("clk_1hz",   clk_1hz,   longint'((m_quarters % 4) >= 2));
    check("blink",     blink,     longint'((m_quarters % 2) == 1));
    check("scan_tick", scan_tick, longint'(m_n > 0 && (m_n % SD) == 0));
    check("scan_sel",  scan_sel,  (m_n / SD) % DIGITS);
  endtask

  // Cycles until tick_1hz is seen (inclusive); returns budget on timeout,
  // which the caller's comparison then flags.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      step();
      n++;
      if (tick_1hz) return;
    end
  endtask

  task automatic measure_high(input int budget, output int n);
    n = 0;
    while (clk_1hz && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  int t;

  initial begin
    reset = 1'b1; enable = 1'b0; sync_clr = 1'b0; fast_mode = 1'b0;
`ifdef TICK_CAL_EN
    cal_trim = 8'd0;
`endif
    do_reset();
    check("rst_tick",  tick_1hz,  0);
    check("rst_clk",   clk_1hz,   0);
    check("rst_blink", blink,     0);
    check("rst_scan",  scan_tick, 0);
    check("rst_sel",   scan_sel,  0);

    // Normal run: first tick 32 cycles after release, 50% duty, 64 period.
    enable = 1'b1;
    wait_tick(200, t);    check("first_tick",   t, 32);
    measure_high(200, t); check("clk_high_len", t, 32);
    wait_tick(200, t);    check("clk_low_len",  t, 32);

    // Pause 10 cycles at qc=5: the tick slips by exactly 10 cycles.
    repeat (5) step();
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    wait_tick(200, t); check("paused_tick", t, 59);
    wait_tick(200, t); check("after_pause", t, 64);

    // Fast mode: tick every 16 cycles.
    fast_mode = 1'b1;
    wait_tick(200, t); check("fast_tick_1", t, 16);
    wait_tick(200, t); check("fast_tick_2", t, 16);
    fast_mode = 1'b0;
    wait_tick(200, t); check("back_normal", t, 64);

    // Switch into fast mode while qc=10: wraps on the very next cycle.
    repeat (10) step();
    fast_mode = 1'b1;
    step();
    check("fast_switch_wrap", clk_1hz, 1);
    check("fast_switch_blink", blink, 1);
    wait_tick(200, t); check("fast_switch_tick", t, 12);
    fast_mode = 1'b0;

    // sync_clr held 3 cycles starting at cycle 40 after release.
    do_reset();
    repeat (39) step();
    sync_clr = 1'b1;
    repeat (3) step();
    check("clr_tick",  tick_1hz, 0);
    check("clr_clk",   clk_1hz,  0);
    check("clr_blink", blink,    0);
    sync_clr = 1'b0;
    wait_tick(200, t); check("clr_next_tick", t, 32);

`ifdef TICK_CAL_EN
    cal_trim = 8'sd2;
    wait_tick(300, t);
    wait_tick(300, t); check("cal_plus2", t, 72);
    cal_trim = -8'sd2;
    wait_tick(300, t);
    wait_tick(300, t); check("cal_minus2", t, 56);
    cal_trim = -8'sd20;
    wait_tick(300, t);
    wait_tick(300, t); check("cal_clamp", t, 8);
    fast_mode = 1'b1;
    wait_tick(300, t);
    wait_tick(300, t); check("cal_fast_ignored", t, 16);
    fast_mode = 1'b0;
    cal_trim = 8'd0;
`endif

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      sync_clr = ($urandom_range(0, 29) == 0) || (sync_clr && $urandom_range(0, 1) == 1);
      enable   = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 79) == 0) fast_mode = ~fast_mode;
`ifdef TICK_CAL_EN
      if ($urandom_range(0, 99) < 5) cal_trim = 8'($urandom);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
